// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Purpose  : Keypad side of a 4x4 row/column scan matrix. Key codes are
//            queued through a small FIFO. Each queued key is held pressed
//            for HOLD_CYCLES and then released for GAP_CYCLES. While a key
//            is pressed, the emulator answers the decoder's column strobes
//            on the row lines, as a physical switch matrix would.
// Ports    : clk        - system clock (the decoder's scan clock)
//            rst        - synchronous, active-high reset
//            key_in     - key code to queue ({row[1:0], col[1:0]})
//            key_valid  - push request
//            key_ready  - FIFO not full; a push is taken when valid&&ready
//            col        - column strobes from the decoder, active-low
//            row        - row lines to the decoder, active-low, registered
//            busy       - high while a key is pressed or in its release gap
//            cur_key    - code of the key most recently popped
//            fifo_count - number of queued entries
// Options  : define KEYPAD_EMULATOR_BOUNCE_EN to add contact chatter during
//            the first BOUNCE_CYCLES cycles of each press.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 1000,
    parameter int FIFO_AW       = 2,
    parameter int BOUNCE_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [3:0]         col,
    output logic [3:0]         row,
    output logic               busy,
    output logic [3:0]         cur_key,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int c_depth_int = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW + 1)'(c_depth_int);

    // A single down-counter serves both the hold and the gap phases, so it
    // is sized for the larger of the two load values.
    localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 || FIFO_AW < 1) begin : g_bad_param
        $error("keypad_emulator: HOLD/GAP/BOUNCE_CYCLES and FIFO_AW must be >= 1");
    end

    logic [3:0]          r_mem [c_depth_int];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;
    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [3:0]          r_cur;
    logic                r_busy;
    logic [3:0]          r_row;

    logic                w_push;
    logic                w_pop;
    logic                w_contact;
    logic [3:0]          w_row_next;

    // Readiness comes only from the registered count, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign key_ready  = (r_count != c_depth);
    assign w_push     = key_valid && key_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);

    assign row        = r_row;
    assign busy       = r_busy;
    assign cur_key    = r_cur;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Press / release sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur   <= r_mem[r_rd_ptr];
                        r_cnt   <= c_hold_load;
                        r_state <= S_PRESS;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRESS: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= c_gap_load;
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Contact state of the pressed key
    // ------------------------------------------------------------------
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    logic [c_cnt_w-1:0] w_elapsed;
    logic [31:0]        w_elapsed_ext;

    // Cycles spent in PRESS so far, derived from the hold counter so no
    // second counter is needed. The contact starts closed and flips every
    // four cycles until the chatter window ends.
    assign w_elapsed     = c_hold_load - r_cnt;
    assign w_elapsed_ext = 32'(w_elapsed);
    assign w_contact     = (w_elapsed_ext < 32'(BOUNCE_CYCLES)) ? ~w_elapsed_ext[2] : 1'b1;
`else
    assign w_contact     = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Switch matrix: the pressed key shorts its row to its column, so the
    // row reads low exactly when that column is strobed (other strobes
    // being low at the same time do not matter).
    // ------------------------------------------------------------------
    always_comb begin
        w_row_next = 4'hF;
        if ((r_state == S_PRESS) && w_contact && !col[r_cur[1:0]]) begin
            w_row_next[r_cur[3:2]] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= 4'hF;
        end else begin
            r_row <= w_row_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Purpose  : Self-checking bench for keypad_emulator. A transaction-level
//            model (queue of keys plus press start times) predicts row,
//            busy, cur_key, fifo_count and key_ready after every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int B_HOLD   = 40;
    localparam int B_BOUNCE = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic [3:0] cur_key;
    logic [2:0] fifo_count;

    logic [3:0] b_key;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_col;
    logic [3:0] b_row;
    logic       b_busy;
    logic [3:0] b_cur;
    logic [2:0] b_count;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_AW(2), .BOUNCE_CYCLES(B_BOUNCE)
    ) u_dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .col(col), .row(row), .busy(busy),
        .cur_key(cur_key), .fifo_count(fifo_count)
    );

    keypad_emulator #(
        .HOLD_CYCLES(B_HOLD), .GAP_CYCLES(GAP), .FIFO_AW(2), .BOUNCE_CYCLES(B_BOUNCE)
    ) u_dut_bounce (
        .clk(clk), .rst(rst), .key_in(b_key), .key_valid(b_valid),
        .key_ready(b_ready), .col(b_col), .row(b_row), .busy(b_busy),
        .cur_key(b_cur), .fifo_count(b_count)
    );

    // ---------------- reference model ----------------
    int         q[$];
    int         cyc       = 0;      // index of the upcoming clock edge
    int         p_start   = -100000;
    int         p_key     = 0;
    int         next_free = 0;
    logic [3:0] exp_row   = 4'hF;
    logic [3:0] exp_cur   = 4'h0;
    logic       exp_busy  = 1'b0;
    logic       exp_ready = 1'b1;
    int         exp_count = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // A key popped at edge s is seen on the rows after edges s+1..s+HOLD,
    // the emulator is busy after edges s..s+HOLD+GAP-1, and the next pop
    // may happen at edge s+HOLD+GAP+1 at the earliest.
    task automatic model_edge(input logic r, input logic v, input logic [3:0] k, input logic [3:0] c);
        int pre;
        logic [3:0] rw;
        if (r) begin
            q.delete();
            p_start   = -100000;
            p_key     = 0;
            next_free = cyc + 1;
            exp_row   = 4'hF;
            exp_cur   = 4'h0;
        end else begin
            pre = q.size();
            rw  = 4'hF;
            if (cyc >= p_start + 1 && cyc <= p_start + HOLD && c[p_key % 4] == 1'b0)
                rw[p_key / 4] = 1'b0;
            exp_row = rw;
            if (pre > 0 && cyc >= next_free) begin
                p_key     = q.pop_front();
                p_start   = cyc;
                next_free = cyc + HOLD + GAP + 1;
                exp_cur   = 4'(p_key);
            end
            if (v && pre < 4) q.push_back(int'(k));
        end
        exp_count = q.size();
        exp_ready = (exp_count < 4);
        exp_busy  = (cyc >= p_start) && (cyc <= p_start + HOLD + GAP - 1);
        cyc++;
    endtask

    task automatic tick();
        logic s_rst, s_v;
        logic [3:0] s_k, s_c;
        s_rst = rst; s_v = key_valid; s_k = key_in; s_c = col;
        @(posedge clk);
        model_edge(s_rst, s_v, s_k, s_c);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_in = 4'h0; col = 4'hF;
        b_valid = 1'b0; b_key = 4'h0; b_col = 4'hF;
        tick(); tick();
        n_cmp++; if (row !== 4'hF) begin n_bad++; $display("FAIL reset_row got=%b exp=1111", row); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", key_ready); end
        n_cmp++; if (cur_key !== 4'h0) begin n_bad++; $display("FAIL reset_cur got=%h exp=0", cur_key); end
        rst = 1'b0; key_in = 4'h6; key_valid = 1'b1; col = 4'b1011;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (row !== 4'b1101) begin n_bad++; $display("FAIL midpress_row got=%b exp=1101", row); end
        key_in = 4'h3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (row !== exp_row || row !== 4'hF) begin n_bad++; $display("FAIL rst_midpress_row got=%b exp=1111", row); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_midpress_busy got=%b exp=0", busy); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_midpress_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_matrix();
        key_in = 4'h6; key_valid = 1'b1; col = 4'b1011;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (i == 4)       col = 4'b1110;
            else if (i == 6)  col = 4'b0000;
            else if (i == 7)  col = 4'b1111;
            else if (i == 14) begin col = 4'b0111; key_in = 4'hF; key_valid = 1'b1; end
            else if (i > 14)  col = ~(4'b0001 << (i % 4));   // walking-zero scan
            else              col = 4'b1011;
            tick();
            key_valid = 1'b0;
            n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL matrix_row cyc=%0d got=%b exp=%b", cyc, row, exp_row); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL matrix_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            n_cmp++; if (cur_key !== exp_cur) begin n_bad++; $display("FAIL matrix_cur cyc=%0d got=%h exp=%h", cyc, cur_key, exp_cur); end
        end
    endtask

    task automatic test_back_to_back();
        int budget;
        key_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            key_in = 4'($urandom);
            col    = 4'($urandom);
            tick();
            n_cmp++; if (fifo_count !== 3'(exp_count)) begin n_bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_count); end
            n_cmp++; if (key_ready !== exp_ready) begin n_bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, key_ready, exp_ready); end
        end
        key_valid = 1'b0;
        budget = 0;
        while ((q.size() != 0 || exp_busy) && budget < 200) begin
            col = 4'($urandom);
            tick();
            budget++;
            n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL b2b_row cyc=%0d got=%b exp=%b", cyc, row, exp_row); end
            n_cmp++; if (cur_key !== exp_cur) begin n_bad++; $display("FAIL b2b_cur cyc=%0d got=%h exp=%h", cyc, cur_key, exp_cur); end
            n_cmp++; if (fifo_count !== 3'(exp_count)) begin n_bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_count); end
        end
        if (budget >= 200) begin n_cmp++; n_bad++; $display("FAIL b2b_drain timeout got=%0d exp<200", budget); end
    endtask

    task automatic test_full_push_pop();
        int budget;
        key_valid = 1'b1; col = 4'b0000;
        for (int i = 0; i < 5; i++) begin key_in = 4'(i + 8); tick(); end
        key_valid = 1'b0;
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        // three pop points: full push+pop, plain pop, push+pop at count 2
        for (int p = 0; p < 3; p++) begin
            budget = 0;
            while (cyc != next_free && budget < 100) begin tick(); budget++; end
            if (budget >= 100) begin n_cmp++; n_bad++; $display("FAIL popwait timeout got=%0d exp<100", budget); end
            key_in = 4'(p + 1); key_valid = (p != 1);
            tick();
            key_valid = 1'b0;
            n_cmp++;
            if (fifo_count !== 3'(exp_count) || (p == 0 && fifo_count !== 3'd3) || (p == 2 && fifo_count !== 3'd2)) begin
                n_bad++; $display("FAIL pushpop_count p=%0d got=%0d exp=%0d", p, fifo_count, exp_count);
            end
            n_cmp++; if (cur_key !== exp_cur) begin n_bad++; $display("FAIL pushpop_cur p=%0d got=%h exp=%h", p, cur_key, exp_cur); end
        end
        budget = 0;
        while ((q.size() != 0 || exp_busy) && budget < 200) begin
            tick(); budget++;
            n_cmp++; if (cur_key !== exp_cur) begin n_bad++; $display("FAIL order_cur cyc=%0d got=%h exp=%h", cyc, cur_key, exp_cur); end
            n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL order_row cyc=%0d got=%b exp=%b", cyc, row, exp_row); end
        end
        if (budget >= 200) begin n_cmp++; n_bad++; $display("FAIL order_drain timeout got=%0d exp<200", budget); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            key_valid = ($urandom_range(0, 2) == 0);
            key_in    = 4'($urandom);
            col       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ~(4'b0001 << (i % 4));
            tick();
            n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL rnd_row cyc=%0d got=%b exp=%b", cyc, row, exp_row); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            n_cmp++; if (cur_key !== exp_cur) begin n_bad++; $display("FAIL rnd_cur cyc=%0d got=%h exp=%h", cyc, cur_key, exp_cur); end
            n_cmp++; if (fifo_count !== 3'(exp_count)) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_count); end
            n_cmp++; if (key_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, key_ready, exp_ready); end
        end
        key_valid = 1'b0;
    endtask

    // Key 9 = row 2, column 1; all columns strobed low for the whole press.
    task automatic test_bounce();
        logic [3:0] exp_b;
        logic       closed;
        int         k;
        b_col = 4'b0000; b_key = 4'h9; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int j = 0; j < 50; j++) begin
            tick();
            k = j - 1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            closed = (k < B_BOUNCE) ? (((k / 4) % 2) == 0) : 1'b1;
`else
            closed = 1'b1;
`endif
            exp_b = (k >= 0 && k < B_HOLD && closed) ? 4'b1011 : 4'b1111;
            n_cmp++; if (b_row !== exp_b) begin n_bad++; $display("FAIL bounce_row k=%0d got=%b exp=%b", k, b_row, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_matrix();
        test_back_to_back();
        test_full_push_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Plays the keypad side of the 4x4 row/column scan interface: reads the column strobes driven by the keypad decoder and drives the row lines as a physical matrix would while a key is held.
- Key presses are queued from a stimulus source, either a bench or the on-board scripted-input path, through a small FIFO.
- Each queued press is held for a fixed time, then released for a fixed gap.
- Lets the decoder, state machine and digit-entry path be exercised without a physical keypad.

Parameters:
- HOLD_CYCLES, 1000: clk cycles a key stays pressed (>=1).
- GAP_CYCLES, 1000: clk cycles of release after each press (>=1).
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW = 4.
- BOUNCE_CYCLES, 64: length of the chatter window; used only with the optional feature.

Ports:
- clk  in  1  system clock (same slow clock as the decoder).
- rst  in  1  synchronous, active-high reset.
- key_in  in  4  key code to queue: row index = key_in[3:2], col index = key_in[1:0].
- key_valid  in  1  push request.
- key_ready  out  1  FIFO not full; push accepted on clk edge when key_valid && key_ready.
- col  in  4  column strobes from decoder, active-low.
- row  out  4  row lines to decoder, active-low, registered.
- busy  out  1  high in PRESS or RELEASE.
- cur_key  out  4  code currently being pressed (last popped).
- fifo_count  out  FIFO_AW+1  entries queued.

Behaviour:
- Reset (sync, active-high):
  - row=4'b1111, busy=0, cur_key=0, fifo_count=0, FIFO pointers=0, state=IDLE, counters=0.
  - Reset asserted mid-press releases the key: row=1111 after that edge, and the queue is discarded.
- FIFO:
  - Circular buffer with wrap-around pointers and explicit count.
  - key_ready = (fifo_count != depth), combinational from the registered count.
  - Push while full is ignored: no overwrite, count unchanged.
  - Simultaneous push and pop: both happen, count unchanged. When full, the push is refused even if a pop occurs the same cycle.
- FSM states IDLE, PRESS, RELEASE:
  - IDLE: if fifo_count!=0, pop the head into cur_key, load hold counter = HOLD_CYCLES-1, go to PRESS. Otherwise stay.
  - PRESS: counter decrements each cycle. At 0, load gap counter = GAP_CYCLES-1 and go to RELEASE. The key is pressed for exactly HOLD_CYCLES cycles.
  - RELEASE: counter decrements. At 0, go to IDLE. Back-to-back keys are separated by GAP_CYCLES+1 cycles of release, including the IDLE pop cycle.
- Matrix model, evaluated every cycle and registered (1-cycle latency from col to row):
  - row[r] = 0 iff state==PRESS and r==cur_key[3:2] and col[cur_key[1:0]]==0. All other row bits are 1.
  - Several col bits low at once: row is driven low whenever the pressed key's column is among them.
  - col=1111: row=1111.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: KEYPAD_EMULATOR_BOUNCE_EN.
- Defined:
  - During the first BOUNCE_CYCLES cycles of PRESS, an internal contact bit toggles every 4 cycles, starting closed. row follows the matrix rule only while the contact is closed, else row=1111.
  - After the window the contact stays closed for the remainder of HOLD_CYCLES; the total PRESS length is unchanged.
  - If HOLD_CYCLES <= BOUNCE_CYCLES, chatter lasts the whole press.
- Not defined: the contact is always closed in PRESS; no bounce logic is synthesized.

Test Plan:
- Reset with HOLD=8, GAP=4: after reset row=1111, busy=0, fifo_count=0, key_ready=1. Push 4'h6 mid-PRESS, then assert rst for 1 cycle: next cycle row=1111, busy=0, fifo_count=0.
- Push key 4'h6 (row1,col2), drive col=1011: after pop, row=1101 one cycle after col settles. col=1110: row=1111. Exactly 8 cycles pressed, then 1111 for the gap.
- Push 5 keys back-to-back with key_valid held high: first 4 accepted with key_ready then 0; fifth ignored unless a pop frees space. The press order at row/cur_key matches the push order; FIFO wraps correctly over 6+ keys.
- Full FIFO: push and pop in the same cycle: push refused, count goes 4->3. Count 2 with push+pop: count stays 2, data order intact.
- Decoder loopback: connect to the keypad decoder scanning col. Push 4'h0, 4'hF, 4'h9: decoder output sequence decodes each key exactly once per press.
- With KEYPAD_EMULATOR_BOUNCE_EN (BOUNCE=16, HOLD=40) and col of the pressed key held low: row pattern closed4/open4 x2, then steady low for 24 cycles. Without the macro: steady low for 40 cycles.
